pulse_divider_bank: RTL and testbench
=====================================

# pulse_divider_bank

Parametrised free-running/burst counter that produces a bank of registered, glitch-free divided pulse outputs plus a wrap strobe. It sits beside the clock generator in power-estimation example designs and supplies activity sources at programmable rates: taps at 1/2, 1/4, 1/8, … of the clock, an arbitrary terminal count, and an optional fixed-length burst mode for peak-power windows.

## Interface
Parameters:
- `WIDTH`, 8: counter width in bits; must be ≥ 2.
- `NUM_TAPS`, 4: number of pulse taps; 1 ≤ `NUM_TAPS` ≤ `WIDTH`.
- `BURST_W`, 8: width of the burst length counter.

Ports:
- `clk`, input, 1: clock; all logic on rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `en`, input, 1: count enable; low freezes all state.
- `clr`, input, 1: synchronous clear; overrides `en`.
- `free_run`, input, 1: 1 = continuous mode; 0 = burst mode.
- `period`, input, `WIDTH`: terminal count; counter sequence is 0..`period`.
- `start`, input, 1: burst start request.
- `burst_len`, input, `BURST_W`: number of wraps per burst.
- `cnt`, output, `WIDTH`: current count.
- `pulse`, output, `NUM_TAPS`: registered tap outputs.
- `wrap`, output, 1: high in the cycle `cnt == period` while active.
- `busy`, output, 1: high while the burst FSM is in RUN.
- `done`, output, 1: one-cycle strobe when a burst completes.

## Operation
- Reset: `cnt`=0, `pulse`=0, `wrap`=0, `busy`=0, `done`=0, FSM=IDLE.
- active = `en` && (`free_run` || FSM==RUN).
- Count step when active: `cnt` == `period` → 0, else `cnt`+1. Wrap is compared against `period` sampled every cycle; if `period` is lowered below `cnt`, the counter runs up to all-ones, wraps to 0 naturally, then obeys the new `period`.
- `period`=0: `cnt` stays 0, `wrap` high every active cycle.
- `pulse[k]` = active && `cnt[k:0]` all ones. Registered from next-state, so it aligns with the `cnt` value it decodes. Non power-of-two periods give irregular tap spacing; this is by design.
- `wrap` = active && `cnt` == `period`, aligned with `cnt`.
- Burst FSM (IDLE, RUN):
  - IDLE → RUN on `start` && `burst_len` ≠ 0 && !`clr`; `cnt` is forced to 0 and the wrap counter cleared.
  - RUN: the wrap counter increments on each active wrap. On the wrap that makes it equal to `burst_len`, go to IDLE and pulse `done` the next cycle.
  - `start` in RUN is ignored; `start` with `burst_len`=0 is ignored.
  - `burst_len` is captured at start; later changes have no effect.
  - `free_run`=1 in RUN forces IDLE with no `done`.
- `clr`: `cnt`=0, `pulse`=0, `wrap`=0, FSM → IDLE (burst aborted, no `done`), wrap counter 0. `clr` and `start` together: `clr` wins.
- `en` low: `cnt` and the FSM hold; `pulse`/`wrap` deassert.

## Timing
- `cnt`, `pulse`, `wrap`, `busy` and `done` are all flops; there are no combinational paths from inputs to outputs.
- `start` at edge N: `busy`=1 and `cnt`=0 after edge N; first increment at edge N+1.
- Burst length = `burst_len`×(`period`+1) active cycles. The final wrap cycle is the last cycle with `busy`=1. `done`=1 for exactly one cycle, the cycle after the final wrap cycle, concurrent with `busy`=0.
- Asynchronous `rst` mid-burst returns all outputs to their reset values immediately; there is no `done`.

## Configuration
- `PULSE_DIVIDER_BURST_EN` defined: the burst FSM, wrap counter, `start`/`burst_len`/`busy`/`done` behave as above.
- Not defined: the FSM is removed; active = `en` regardless of `free_run`. `busy` = 0, `done` = 0; `start`, `burst_len` and `free_run` are ignored.

## Test plan
- Reset then `en`=1, `free_run`=1, `period`=255, `WIDTH`=8, `NUM_TAPS`=4 → `pulse[0]` every 2 cycles, `pulse[3]` every 16 cycles (first high at `cnt`=15), `wrap` once per 256 cycles.
- `period`=5 → `cnt` sequence 0,1,2,3,4,5,0; `wrap` at `cnt`=5; `pulse[0]` at 1, 3, 5; `pulse[1]` at 3 only.
- Burst mode, `period`=3, `burst_len`=2, `start` pulse → `busy` high for 8 cycles, `done` one cycle after, `cnt` frozen at 0 afterwards; a second `start` mid-burst is ignored.
- `en` toggled low for 3 cycles mid-count at `cnt`=7 → `cnt` holds 7, `pulse` is 0 during the stall, and counting resumes at 8.
- `clr` asserted with `start` during RUN → `cnt`=0, `busy`=0, `done` never asserts; `burst_len`=0 `start` → stays IDLE.
- `rst` asserted asynchronously mid-burst (between edges) → all outputs 0 before the next edge; build without `PULSE_DIVIDER_BURST_EN` → `busy`/`done` always 0 and counting follows `en` only.

Source files
------------

// File: rtl/pulse_divider_bank.sv
// -----------------------------------------------------------------------------
// pulse_divider_bank
//
// Free-running / burst counter that produces a bank of registered, glitch-free
// divided pulse taps plus a wrap strobe. It is used as a programmable activity
// source: tap k fires whenever the low k+1 count bits are all ones, so with a
// power-of-two period tap k runs at clk / 2^(k+1).
//
// Optional feature macro: PULSE_DIVIDER_BURST_EN
//   defined     : burst FSM (IDLE/RUN), wrap counter and captured burst length
//                 are built; start/burst_len/free_run/busy/done are live.
//   not defined : counting follows en only; busy and done are tied low and
//                 start, burst_len and free_run are ignored.
//
// Parameters
//   WIDTH    : counter width (>= 2)
//   NUM_TAPS : number of pulse taps (1..WIDTH)
//   BURST_W  : width of the burst length / wrap counter
//
// Ports
//   clk       in   clock, everything on the rising edge
//   rst       in   asynchronous active-high reset
//   en        in   count enable; low freezes counter and FSM
//   clr       in   synchronous clear, overrides en and start
//   free_run  in   1 = continuous counting, 0 = burst mode
//   period    in   terminal count, sequence is 0..period
//   start     in   burst start request
//   burst_len in   number of wraps per burst (captured at start)
//   cnt       out  current count
//   pulse     out  registered tap outputs
//   wrap      out  high in the cycle cnt == period while counting
//   busy      out  high while a burst is running
//   done      out  one-cycle strobe after the final wrap of a burst
// -----------------------------------------------------------------------------
module pulse_divider_bank #(
    parameter int WIDTH    = 8,
    parameter int NUM_TAPS = 4,
    parameter int BURST_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                clr,
    input  logic                free_run,
    input  logic [WIDTH-1:0]    period,
    input  logic                start,
    input  logic [BURST_W-1:0]  burst_len,
    output logic [WIDTH-1:0]    cnt,
    output logic [NUM_TAPS-1:0] pulse,
    output logic                wrap,
    output logic                busy,
    output logic                done
);

    localparam logic [WIDTH-1:0] CNT_ONE = 1;

    logic [WIDTH-1:0]    cnt_reg;
    logic [WIDTH-1:0]    cnt_next;
    logic [NUM_TAPS-1:0] pulse_reg;
    logic [NUM_TAPS-1:0] pulse_next;
    logic                wrap_reg;
    logic                wrap_next;

    // active     : the counter steps at this edge
    // out_active : the cycle after this edge is a counting cycle (assuming en
    //              stays high); pulse/wrap are decoded from the next count
    //              and qualified with this, so they line up with cnt.
    // force_zero : counter is forced to 0 (clear or burst start)
    logic active;
    logic out_active;
    logic force_zero;
    logic at_terminal;

    assign at_terminal = (cnt_reg == period);

`ifdef PULSE_DIVIDER_BURST_EN

    localparam logic [BURST_W-1:0] BURST_ONE = 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_reg;
    logic [BURST_W-1:0] wraps_reg;
    logic [BURST_W-1:0] blen_reg;
    logic               done_reg;

    logic burst_start;
    logic final_wrap;
    logic run_next;

    assign active = en && (free_run || (state_reg == RUN));

    // A burst only starts from IDLE while enabled and in burst mode; with en
    // low the FSM holds, and with free_run high a burst has no meaning.
    assign burst_start = (state_reg == IDLE) && en && start && !free_run &&
                         (burst_len != '0) && !clr;

    // The wrap that brings the wrap count up to the captured length.
    assign final_wrap = (state_reg == RUN) && active && at_terminal &&
                        ((wraps_reg + BURST_ONE) == blen_reg);

    // Whether the FSM will be in RUN after this edge; mirrors the FSM below.
    assign run_next = !clr &&
                      (burst_start ||
                       ((state_reg == RUN) && !(en && free_run) && !final_wrap));

    assign out_active = !clr && en && (free_run || run_next);
    assign force_zero = clr || burst_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            wraps_reg <= '0;
            blen_reg  <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (clr) begin
                // Abort without a done strobe.
                state_reg <= IDLE;
                wraps_reg <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (burst_start) begin
                            state_reg <= RUN;
                            wraps_reg <= '0;
                            blen_reg  <= burst_len;
                        end
                    end
                    RUN: begin
                        if (en && free_run) begin
                            // Switching to continuous mode drops the burst.
                            state_reg <= IDLE;
                            wraps_reg <= '0;
                        end else if (active && at_terminal) begin
                            if (final_wrap) begin
                                state_reg <= IDLE;
                                wraps_reg <= '0;
                                done_reg  <= 1'b1;
                            end else begin
                                wraps_reg <= wraps_reg + BURST_ONE;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign busy = (state_reg == RUN);
    assign done = done_reg;

`else

    assign active     = en;
    assign out_active = en && !clr;
    assign force_zero = clr;

    // Burst controls have no effect in this build.
    logic unused_burst_inputs;
    assign unused_burst_inputs = ^{start, burst_len, free_run};

    assign busy = 1'b0;
    assign done = 1'b0;

`endif

    // Count step: wrap to 0 at the terminal count, otherwise increment. If
    // period is lowered below cnt the increment simply overflows to 0.
    always_comb begin
        cnt_next = cnt_reg;
        if (force_zero) begin
            cnt_next = '0;
        end else if (active) begin
            cnt_next = at_terminal ? '0 : (cnt_reg + CNT_ONE);
        end
    end

    // Tap k decodes the low k+1 bits of the next count.
    for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
        assign pulse_next[gi] = out_active && (&cnt_next[gi:0]);
    end

    assign wrap_next = out_active && (cnt_next == period);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg   <= '0;
            pulse_reg <= '0;
            wrap_reg  <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            pulse_reg <= pulse_next;
            wrap_reg  <= wrap_next;
        end
    end

    assign cnt   = cnt_reg;
    assign pulse = pulse_reg;
    assign wrap  = wrap_reg;

endmodule

// File: tb/tb_pulse_divider_bank.sv
// -----------------------------------------------------------------------------
// Testbench for pulse_divider_bank. A driver applies directed and random
// stimulus and, at each rising edge, advances a behavioural model and queues
// the expected outputs; a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_pulse_divider_bank;

    localparam int WIDTH    = 8;
    localparam int NUM_TAPS = 4;
    localparam int BURST_W  = 8;
    localparam int CNT_MOD  = 1 << WIDTH;

`ifdef PULSE_DIVIDER_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic                clr;
    logic                free_run;
    logic [WIDTH-1:0]    period;
    logic                start;
    logic [BURST_W-1:0]  burst_len;
    logic [WIDTH-1:0]    cnt;
    logic [NUM_TAPS-1:0] pulse;
    logic                wrap;
    logic                busy;
    logic                done;

    pulse_divider_bank #(
        .WIDTH    (WIDTH),
        .NUM_TAPS (NUM_TAPS),
        .BURST_W  (BURST_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clr       (clr),
        .free_run  (free_run),
        .period    (period),
        .start     (start),
        .burst_len (burst_len),
        .cnt       (cnt),
        .pulse     (pulse),
        .wrap      (wrap),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int pulse;
        bit wrap;
        bit busy;
        bit done;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   txn    = 0;

    // Reference model state: current count, whether a burst is running and how
    // many wraps it still has to make.
    int m_cnt     = 0;
    bit m_running = 1'b0;
    int m_left    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL txn %0d %s: got %0d expected %0d", txn, name, act, expv);
        end
    endtask

    // One clock edge of the reference model, using the inputs now applied.
    task automatic model_step();
        exp_t e;
        bit   act;
        bit   on;
        int   n;
        n      = m_cnt;
        act    = 1'b0;
        on     = 1'b0;
        e.done = 1'b0;
        if (rst || clr) begin
            n         = 0;
            m_running = 1'b0;
            m_left    = 0;
        end else begin
            act = en && (!BURST || free_run || m_running);
            if (BURST && !m_running && en && start && !free_run && burst_len != 0) begin
                m_running = 1'b1;
                m_left    = burst_len;
                n         = 0;
            end else if (BURST && m_running && en && free_run) begin
                m_running = 1'b0;
            end else if (BURST && m_running && act && m_cnt == period) begin
                m_left--;
                if (m_left == 0) begin
                    m_running = 1'b0;
                    e.done    = 1'b1;
                end
            end
            if (act) n = (m_cnt == period) ? 0 : (m_cnt + 1) % CNT_MOD;
            on = en && (!BURST || free_run || m_running);
        end
        m_cnt   = n;
        e.cnt   = n;
        e.wrap  = on && (n == period);
        e.busy  = m_running;
        e.pulse = 0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            if (on && ((n + 1) % (1 << (k + 1))) == 0) e.pulse = e.pulse | (1 << k);
        end
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // Monitor: every cycle the DUT presents a new output set.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            txn++;
            check("cnt",   32'(cnt),   32'(mon_e.cnt));
            check("pulse", 32'(pulse), 32'(mon_e.pulse));
            check("wrap",  32'(wrap),  32'(mon_e.wrap));
            check("busy",  32'(busy),  32'(mon_e.busy));
            check("done",  32'(done),  32'(mon_e.done));
            $display("txn %0d: cnt=%0d pulse=%b wrap=%0b busy=%0b done=%0b (exp cnt=%0d pulse=%0d wrap=%0b busy=%0b done=%0b)",
                     txn, cnt, pulse, wrap, busy, done,
                     mon_e.cnt, mon_e.pulse, mon_e.wrap, mon_e.busy, mon_e.done);
        end
    end

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        clr       = 1'b0;
        free_run  = 1'b1;
        start     = 1'b0;
        period    = 8'd255;
        burst_len = '0;
        @(negedge clk);
        repeat (3) tick();
        rst = 1'b0;

        // Free-running full-range count: taps at 1/2..1/16, wrap every 256.
        en = 1'b1;
        repeat (300) tick();

        // Short period 0..5.
        clr = 1'b1;
        tick();
        clr    = 1'b0;
        period = 8'd5;
        repeat (20) tick();

        // Enable stall at cnt = 7.
        clr    = 1'b1;
        period = 8'd255;
        tick();
        clr = 1'b0;
        repeat (7) tick();
        en = 1'b0;
        repeat (3) tick();
        en = 1'b1;
        repeat (5) tick();

        // Period lowered below the current count: run up to all-ones first.
        period = 8'd3;
        repeat (250) tick();

        // Period 0: wrap every active cycle.
        period = 8'd0;
        repeat (5) tick();

        // Burst: period 3, two wraps; a second start mid-burst is ignored.
        clr = 1'b1;
        tick();
        clr       = 1'b0;
        free_run  = 1'b0;
        period    = 8'd3;
        burst_len = 8'd2;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        start     = 1'b1;
        burst_len = 8'd5;
        tick();
        start = 1'b0;
        repeat (10) tick();

        // clr together with start during a burst, then a zero-length start.
        burst_len = 8'd3;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        clr   = 1'b1;
        start = 1'b1;
        tick();
        clr   = 1'b0;
        start = 1'b0;
        repeat (6) tick();
        burst_len = 8'd0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();

        // Asynchronous reset between edges in the middle of a burst.
        burst_len = 8'd4;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        check("async_rst_cnt",   32'(cnt),   32'd0);
        check("async_rst_pulse", 32'(pulse), 32'd0);
        check("async_rst_wrap",  32'(wrap),  32'd0);
        check("async_rst_busy",  32'(busy),  32'd0);
        check("async_rst_done",  32'(done),  32'd0);
        tick();
        rst = 1'b0;
        repeat (3) tick();

        // Random mix of all controls.
        period   = 8'd4;
        free_run = 1'b1;
        for (int i = 0; i < 400; i++) begin
            en    = ($urandom_range(0, 9) != 0);
            clr   = ($urandom_range(0, 49) == 0);
            start = ($urandom_range(0, 9) == 0);
            burst_len = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) free_run = ~free_run;
            if ($urandom_range(0, 39) == 0) period = 8'($urandom_range(0, 9));
            tick();
        end
        clr   = 1'b0;
        start = 1'b0;
        repeat (2) tick();

        // Let the monitor drain the queue, then confirm nothing is left.
        @(posedge clk);
        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
